// File: rtl/redmule_x_feeder.sv
// redmule_x_feeder
//   Upstream stage of the X buffer. X-operand beats from the streamer are
//   accepted over valid/ready and held in a small FIFO. Each X-buffer load
//   slot gets one load strobe and one data word. Elements past the leftover
//   count in the final block are zero-padded. Block refills are paced against
//   the X-buffer full flag and the controller's block-consume pulse.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous clear (flush FIFO, zero counters, IDLE)
//   start_i                tile start pulse, only honoured in IDLE
//   loads_per_block_i      loads per X-buffer block (>=1), sampled at start
//   n_blocks_i             blocks per tile (>=1), sampled at start
//   lftovr_elems_i         valid elements per word in last block, 0 = all
//   x_data_i/x_valid_i     stream input
//   x_ready_o              stream ready
//   buf_full_i             X-buffer full, stalls loads
//   blck_consumed_i        controller consumed the current block
//   load_o/x_buffer_o      X-buffer load strobe and word
//   busy_o                 high outside IDLE
//   done_o                 one-cycle tile completion pulse
module redmule_x_feeder #(
   parameter int unsigned DW         = 288,
   parameter int unsigned BITW       = 16,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         clear_i,
   input  logic                         start_i,
   input  logic [CNT_W-1:0]             loads_per_block_i,
   input  logic [CNT_W-1:0]             n_blocks_i,
   input  logic [$clog2(DW/BITW):0]     lftovr_elems_i,
   input  logic [DW-1:0]                x_data_i,
   input  logic                         x_valid_i,
   output logic                         x_ready_o,
   input  logic                         buf_full_i,
   input  logic                         blck_consumed_i,
   output logic                         load_o,
   output logic [DW-1:0]                x_buffer_o,
   output logic                         busy_o,
   output logic                         done_o
);

   localparam int unsigned NEL = DW / BITW;
   localparam int unsigned LW  = $clog2(NEL) + 1;
   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam int unsigned OW  = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic [1:0] {IDLE, FILL, WAIT, DONE} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] load_cnt_q, block_cnt_q;
   logic [CNT_W-1:0] lpb_q, nblk_q;
   logic [LW-1:0]    lftovr_q;
   logic             busy_q, done_q;

   logic [DW-1:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [OW-1:0]    occ_q;
   logic             fifo_empty, fifo_full, push, pop, flush;
   logic             last_blk;
   logic [DW-1:0]    head_masked;

   always_comb begin
      fifo_empty = (occ_q == '0);
      fifo_full  = (occ_q == OW'(FIFO_DEPTH));
      // Ready depends only on registered occupancy, so a pop while full
      // frees the slot one cycle later.
      x_ready_o  = !fifo_full && ((state_q == FILL) || (state_q == WAIT));
      push       = x_valid_i && x_ready_o;
      load_o     = (state_q == FILL) && !fifo_empty && !buf_full_i;
      pop        = load_o;
      // Leftover FIFO content at tile end is a protocol error; drop it.
      flush      = clear_i || (state_q == DONE);
   end

   always_comb begin
      last_blk    = (block_cnt_q == nblk_q - CNT_W'(1));
      head_masked = fifo_mem[rd_ptr_q];
      if (last_blk && (lftovr_q != '0)) begin
         for (int unsigned e = 0; e < NEL; e++) begin
            if (e >= 32'(lftovr_q)) head_masked[e*BITW +: BITW] = '0;
         end
      end
      x_buffer_o = load_o ? head_masked : '0;
   end

   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr_q] <= x_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   occ_q <= occ_q + OW'(1);
            2'b01:   occ_q <= occ_q - OW'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         load_cnt_q  <= '0;
         block_cnt_q <= '0;
         lpb_q       <= '0;
         nblk_q      <= '0;
         lftovr_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else if (clear_i) begin
         state_q     <= IDLE;
         load_cnt_q  <= '0;
         block_cnt_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  lpb_q       <= loads_per_block_i;
                  nblk_q      <= n_blocks_i;
                  lftovr_q    <= lftovr_elems_i;
                  load_cnt_q  <= '0;
                  block_cnt_q <= '0;
                  busy_q      <= 1'b1;
                  state_q     <= FILL;
               end
            end
            FILL: begin
               if (load_o) begin
                  if (load_cnt_q == lpb_q - CNT_W'(1)) begin
                     load_cnt_q  <= '0;
                     block_cnt_q <= block_cnt_q + CNT_W'(1);
                     state_q     <= WAIT;
                  end else begin
                     load_cnt_q <= load_cnt_q + CNT_W'(1);
                  end
               end
            end
            WAIT: begin
               if (blck_consumed_i) begin
                  if (block_cnt_q == nblk_q) begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     state_q <= FILL;
                  end
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: tb/tb_redmule_x_feeder.sv
module tb_redmule_x_feeder;

   localparam int unsigned DW    = 288;
   localparam int unsigned BITW  = 16;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned NEL   = DW / BITW;
   localparam int unsigned LW    = $clog2(NEL) + 1;

   logic             clk, rst_n, clear, start;
   logic [CNT_W-1:0] lpb, nblk;
   logic [LW-1:0]    lftovr;
   logic [DW-1:0]    x_data;
   logic             x_valid, x_ready, buf_full, consumed;
   logic             load, busy, done;
   logic [DW-1:0]    x_buffer;

   int               checks = 0;
   int               errors = 0;
   int               done_cnt = 0;
   logic [DW-1:0]    caps[$];

   redmule_x_feeder #(
      .DW(DW), .BITW(BITW), .FIFO_DEPTH(2), .CNT_W(CNT_W)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
      .loads_per_block_i(lpb), .n_blocks_i(nblk), .lftovr_elems_i(lftovr),
      .x_data_i(x_data), .x_valid_i(x_valid), .x_ready_o(x_ready),
      .buf_full_i(buf_full), .blck_consumed_i(consumed),
      .load_o(load), .x_buffer_o(x_buffer), .busy_o(busy), .done_o(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every X-buffer load and done pulse mid-cycle.
   always @(negedge clk) begin
      if (load) caps.push_back(x_buffer);
      if (done) done_cnt++;
   end

   function automatic logic [DW-1:0] rep(input int v);
      logic [BITW-1:0] e;
      e = v[BITW-1:0];
      return {NEL{e}};
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start_tile(input int l, input int n, input int lf);
      lpb = CNT_W'(l); nblk = CNT_W'(n); lftovr = LW'(lf);
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [DW-1:0] d);
      logic acc;
      acc = 1'b0;
      x_data = d;
      x_valid = 1'b1;
      for (int k = 0; k < 60 && !acc; k++) begin
         acc = x_ready;
         cyc();
      end
      x_valid = 1'b0;
      chk("send_timeout", DW'(acc), DW'(1));
   endtask

   task automatic wait_loads(input int n);
      for (int k = 0; k < 200 && caps.size() < n; k++) cyc();
      chk("load_count", DW'(caps.size()), DW'(n));
   endtask

   task automatic pulse_consume();
      consumed = 1'b1;
      cyc();
      consumed = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] part;
      int            nxt;
      logic          acc;

      rst_n = 1'b0; clear = 1'b0; start = 1'b0; lpb = '0; nblk = '0; lftovr = '0;
      x_data = '0; x_valid = 1'b0; buf_full = 1'b0; consumed = 1'b0;
      repeat (3) cyc();
      chk("rst_ready", DW'(x_ready), DW'(0));
      chk("rst_load", DW'(load), DW'(0));
      chk("rst_xbuf", x_buffer, '0);
      chk("rst_busy", DW'(busy), DW'(0));
      chk("rst_done", DW'(done), DW'(0));
      rst_n = 1'b1;
      cyc();

      // Basic tile: 3 loads x 2 blocks, prefetch of block 1 during WAIT.
      caps.delete(); done_cnt = 0;
      start_tile(3, 2, 0);
      chk("basic_busy", DW'(busy), DW'(1));
      for (int i = 1; i <= 3; i++) send_beat(rep(i));
      wait_loads(3);
      chk("wait_ready", DW'(x_ready), DW'(1));
      send_beat(rep(4));
      send_beat(rep(5));
      cyc();
      chk("wait_no_load", DW'(caps.size()), DW'(3));
      chk("wait_full", DW'(x_ready), DW'(0));
      pulse_consume();
      send_beat(rep(6));
      wait_loads(6);
      chk("basic_pre_done", DW'(done), DW'(0));
      pulse_consume();
      chk("basic_done", DW'(done), DW'(1));
      cyc();
      chk("basic_done_end", DW'(done), DW'(0));
      chk("basic_idle", DW'(busy), DW'(0));
      chk("basic_done_cnt", DW'(done_cnt), DW'(1));
      for (int i = 0; i < 6; i++) chk($sformatf("basic_data%0d", i), caps[i], rep(i + 1));

      // Backpressure: loads stalled for 10 cycles with valid held high.
      caps.delete(); done_cnt = 0;
      buf_full = 1'b1;
      start_tile(3, 1, 0);
      nxt = 11;
      for (int k = 0; k < 10; k++) begin
         x_valid = 1'b1; x_data = rep(nxt);
         acc = x_ready;
         cyc();
         if (acc) nxt++;
      end
      chk("bp_accepted", DW'(nxt), DW'(13));
      chk("bp_ready_low", DW'(x_ready), DW'(0));
      chk("bp_no_load", DW'(caps.size()), DW'(0));
      buf_full = 1'b0;
      #1;
      chk("bp_pop_full_load", DW'(load), DW'(1));
      chk("bp_pop_full_ready", DW'(x_ready), DW'(0));
      chk("bp_pop_full_head", x_buffer, rep(11));
      for (int k = 0; k < 20 && nxt <= 13; k++) begin
         x_valid = 1'b1; x_data = rep(nxt);
         acc = x_ready;
         cyc();
         if (acc) nxt++;
      end
      x_valid = 1'b0;
      wait_loads(3);
      for (int i = 0; i < 3; i++) chk($sformatf("bp_data%0d", i), caps[i], rep(11 + i));
      pulse_consume();
      chk("bp_done", DW'(done), DW'(1));
      cyc();

      // Leftover masking: 5 valid elements in the last block.
      caps.delete(); done_cnt = 0;
      start_tile(2, 2, 5);
      send_beat('1);
      send_beat('1);
      wait_loads(2);
      pulse_consume();
      send_beat('1);
      send_beat('1);
      wait_loads(4);
      part = '0;
      part[79:0] = '1;
      chk("mask_blk0_a", caps[0], '1);
      chk("mask_blk0_b", caps[1], '1);
      chk("mask_blk1_a", caps[2], part);
      chk("mask_blk1_b", caps[3], part);
      pulse_consume();
      chk("mask_done", DW'(done), DW'(1));
      cyc();

      // Stray start and consume pulses during FILL.
      caps.delete(); done_cnt = 0;
      start_tile(2, 1, 0);
      pulse_consume();
      start_tile(1, 1, 0);
      send_beat(rep(7));
      wait_loads(1);
      pulse_consume();
      chk("stray_no_done", DW'(done), DW'(0));
      chk("stray_busy", DW'(busy), DW'(1));
      send_beat(rep(8));
      wait_loads(2);
      chk("stray_data1", caps[1], rep(8));
      pulse_consume();
      chk("stray_done", DW'(done), DW'(1));
      chk("stray_done_cnt", DW'(done_cnt), DW'(0));
      cyc();
      chk("stray_done_cnt2", DW'(done_cnt), DW'(1));

      // Asynchronous reset after 2 of 3 loads.
      caps.delete(); done_cnt = 0;
      start_tile(3, 1, 0);
      send_beat(rep(20));
      send_beat(rep(21));
      wait_loads(2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", DW'(busy), DW'(0));
      chk("arst_ready", DW'(x_ready), DW'(0));
      chk("arst_load", DW'(load), DW'(0));
      cyc();
      rst_n = 1'b1;
      cyc();

      // Clear in WAIT with a prefetched beat, then a fresh tile.
      caps.delete(); done_cnt = 0;
      start_tile(1, 1, 0);
      send_beat(rep(9));
      wait_loads(1);
      send_beat(rep(99));
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      chk("clr_busy", DW'(busy), DW'(0));
      chk("clr_ready", DW'(x_ready), DW'(0));
      chk("clr_load", DW'(load), DW'(0));
      chk("clr_xbuf", x_buffer, '0);
      caps.delete();
      start_tile(1, 1, 0);
      send_beat(rep(42));
      wait_loads(1);
      chk("clr_new_data", caps[0], rep(42));
      pulse_consume();
      chk("clr_new_done", DW'(done), DW'(1));
      cyc();
      chk("clr_new_idle", DW'(busy), DW'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
